// File: rtl/gpio_stream_pkg.sv
// Shared types and constants for the GPIO-to-UART byte streamer.
package gpio_stream_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

endpackage

// File: rtl/gpio_uart_streamer_byte_fifo.sv
// Synchronous byte FIFO; occupancy count tells full from empty.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot, so a full FIFO may still take a byte.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
        if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/gpio_uart_streamer.sv
// Buffers GPIO write bytes and sends them as UART frames (8N1).
// Define GPIO_STREAM_PARITY_EN for 8E1 framing.
module gpio_uart_streamer
    import gpio_stream_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          GPIOEn,
    input  logic [7:0]                    GPIO,
    input  logic [31:0]                   GPIOaddr,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   last_addr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   last_addr_q, last_addr_d;

    logic          pop, push_ok, bit_end;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .din   (GPIO),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        bit_end = (cnt_q == CNT_MAX);
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = ^fifo_dout;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: if (bit_end) begin
                state_d = S_DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            S_DATA: if (bit_end) begin
                if (bit_q == LAST_BIT) begin
`ifdef GPIO_STREAM_PARITY_EN
                    state_d = S_PARITY;
                    tx_d    = par_q;
`else
                    state_d = S_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                    bit_d   = bit_q + BW'(1);
                end
            end
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end
            S_STOP: if (bit_end) begin
                // Chain straight into the next frame when data is waiting.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = ^fifo_dout;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        push_ok     = GPIOEn & (~fifo_full | pop);
        // Whenever the FSM rests in IDLE the FIFO is empty, so only a push keeps it busy.
        busy_d      = (state_d != S_IDLE) | push_ok;
        overflow_d  = overflow_q | (GPIOEn & ~push_ok);
        last_addr_d = push_ok ? GPIOaddr : last_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign last_addr = last_addr_q;

endmodule

// File: tb/tb_gpio_uart_streamer.sv
// Directed bench for gpio_uart_streamer at CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_gpio_uart_streamer;

    localparam int CPB = 4;
    localparam int DEPTH = 16;
`ifdef GPIO_STREAM_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        GPIOEn;
    logic [7:0]  GPIO;
    logic [31:0] GPIOaddr;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [4:0]  fifo_count;
    logic [31:0] last_addr;

    int checks = 0;
    int errors = 0;

    gpio_uart_streamer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .GPIOEn     (GPIOEn),
        .GPIO       (GPIO),
        .GPIOaddr   (GPIOaddr),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .last_addr  (last_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for sample k of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NB == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic frame(input logic [7:0] b, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            chk("frame_tx", {31'd0, tx}, {31'd0, exp_bit(b, k)});
            @(negedge clk);
        end
    endtask

    logic [7:0] d [17];
    logic [7:0] e [18];

    initial begin
        for (int i = 0; i < 17; i++) d[i] = 8'(i * 37 + 5);
        for (int i = 0; i < 18; i++) e[i] = 8'(i * 53 + 11);
        rst = 1'b1;
        GPIOEn = 1'b0;
        GPIO = '0;
        GPIOaddr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_addr", last_addr, 32'd0);

        // single byte 0xA5
        GPIOEn = 1'b1; GPIO = 8'hA5; GPIOaddr = 32'h100;
        @(negedge clk);
        GPIOEn = 1'b0;
        chk("a5_count", {27'd0, fifo_count}, 32'd1);
        chk("a5_busy", {31'd0, busy}, 32'd1);
        chk("a5_tx_pre", {31'd0, tx}, 32'd1);
        chk("a5_addr", last_addr, 32'h100);
        @(negedge clk);
        frame(8'hA5, 0, FL - 1);
        chk("a5_busy_end", {31'd0, busy}, 32'd0);
        chk("a5_tx_end", {31'd0, tx}, 32'd1);
        chk("a5_count_end", {27'd0, fifo_count}, 32'd0);

        // back-to-back 0x01, 0x80
        GPIOEn = 1'b1; GPIO = 8'h01; GPIOaddr = 32'h104;
        @(negedge clk);
        GPIO = 8'h80; GPIOaddr = 32'h108;
        chk("b2b_count0", {27'd0, fifo_count}, 32'd1);
        @(negedge clk);
        GPIOEn = 1'b0;
        chk("b2b_count1", {27'd0, fifo_count}, 32'd1);
        chk("b2b_addr", last_addr, 32'h108);
        frame(8'h01, 0, FL - 1);
        frame(8'h80, 0, FL - 1);
        chk("b2b_busy_end", {31'd0, busy}, 32'd0);

        // 0x07: parity bit is 1 when enabled
        GPIOEn = 1'b1; GPIO = 8'h07; GPIOaddr = 32'h10C;
        @(negedge clk);
        GPIOEn = 1'b0;
        @(negedge clk);
        frame(8'h07, 0, FL - 1);
        chk("p07_busy_end", {31'd0, busy}, 32'd0);

        // fill to 16, then push at the STOP->START boundary
        for (int i = 0; i < 17; i++) begin
            GPIOEn = 1'b1; GPIO = d[i]; GPIOaddr = 32'h200 + 32'(i);
            @(negedge clk);
        end
        GPIOEn = 1'b0;
        chk("full_count", {27'd0, fifo_count}, 32'd16);
        chk("full_ovf", {31'd0, overflow}, 32'd0);
        chk("full_addr", last_addr, 32'h210);
        frame(d[0], 15, FL - 2);
        GPIOEn = 1'b1; GPIO = 8'h3C; GPIOaddr = 32'h2FF;
        chk("bnd_tx_stop", {31'd0, tx}, 32'd1);
        chk("bnd_count_pre", {27'd0, fifo_count}, 32'd16);
        @(negedge clk);
        GPIOEn = 1'b0;
        chk("bnd_count", {27'd0, fifo_count}, 32'd16);
        chk("bnd_ovf", {31'd0, overflow}, 32'd0);
        chk("bnd_addr", last_addr, 32'h2FF);
        frame(d[1], 0, FL - 1);
        frame(d[2], 0, 16);

        // reset during data bit 3 with many bytes queued
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_count", {27'd0, fifo_count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_addr", last_addr, 32'd0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("post_rst_tx", {31'd0, tx}, 32'd1);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end

        // 18 consecutive pushes: one popped, 16 stored, one dropped
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            GPIOEn = 1'b1; GPIO = e[i]; GPIOaddr = 32'h300 + 32'(i);
            @(negedge clk);
        end
        GPIOEn = 1'b0;
        chk("ovf_count", {27'd0, fifo_count}, 32'd16);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_addr", last_addr, 32'h310);
        frame(e[0], 16, FL - 1);
        for (int j = 1; j < 17; j++) begin
            frame(e[j], 0, FL - 1);
            chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        end
        chk("ovf_busy_end", {31'd0, busy}, 32'd0);
        chk("ovf_tx_end", {31'd0, tx}, 32'd1);
        chk("ovf_count_end", {27'd0, fifo_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
